auth_request_initiator: RTL and testbench

//  Requester side of the hash-compare authentication handshake. Accepts a credential from the host
//  (valid/ready), drives auth_request/input_hash/password_hash to the compare responder, and samples

---
 rtl/auth_pkg.sv | 21 ++
 rtl/auth_cycle_timer.sv | 40 ++++
 rtl/auth_request_initiator.sv | 181 ++++++++++++++++++
 tb/tb_auth_request_initiator.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/auth_pkg.sv
// -----------------------------------------------------------------------------
// auth_pkg
//   Shared definitions for the hash-compare authentication handshake.
//   Used by both the requester (auth_request_initiator) and the compare
//   responder so that state encodings and the default hash width agree.
// -----------------------------------------------------------------------------
package auth_pkg;

  // Default credential/hash width shared with the responder.
  localparam int HASH_W_DEFAULT = 32;

  // Initiator handshake states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    RESPOND = 3'd3,
    LOCKOUT = 3'd4
  } auth_state_e;

endpackage : auth_pkg

// File: rtl/auth_cycle_timer.sv
// -----------------------------------------------------------------------------
// auth_cycle_timer
//   Load/decrement down counter with a zero flag. One instance times both the
//   compare window and the lockout period of the initiator.
// Ports
//   clk         in   1  clock, rising edge
//   reset_n     in   1  synchronous active-low reset (count -> 0)
//   load        in   1  load load_value (has priority over dec)
//   load_value  in   W  value to load
//   dec         in   1  decrement by one; holds at zero
//   count       out  W  current count
//   zero        out  1  count == 0
// -----------------------------------------------------------------------------
module auth_cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule : auth_cycle_timer

// File: rtl/auth_request_initiator.sv
// -----------------------------------------------------------------------------
// auth_request_initiator
//   Requester side of the hash-compare authentication handshake. Takes a
//   credential from the host, pulses auth_request to the responder with the
//   candidate/reference hashes held stable, samples auth_result only at the
//   end of a fixed window, and returns pass/fail with outcome-independent
//   latency. Consecutive failures are counted; reaching MAX_FAILS triggers a
//   timed lockout.
// Ports
//   clk            in   1       clock, rising edge
//   reset_n        in   1       synchronous active-low reset
//   req_valid      in   1       host credential valid
//   req_ready      out  1       initiator accepts credential (IDLE only)
//   req_hash       in   HASH_W  candidate hash from host
//   ref_hash       in   HASH_W  stored reference hash, sampled with req_hash
//   auth_request   out  1       one-cycle start pulse to responder
//   input_hash     out  HASH_W  candidate hash to responder
//   password_hash  out  HASH_W  reference hash to responder
//   auth_result    in   1       responder verdict, sampled at window end only
//   rsp_valid      out  1       host response valid
//   rsp_pass       out  1       1 = authenticated; 0 whenever rsp_valid = 0
//   rsp_ready      in   1       host accepts response
//   locked         out  1       lockout active
//   fail_count     out  FAIL_W  consecutive failure count
// -----------------------------------------------------------------------------
module auth_request_initiator
  import auth_pkg::*;
#(
  parameter int HASH_W         = HASH_W_DEFAULT,
  parameter int COMPARE_CYCLES = 24,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 256,
  parameter int FAIL_W         = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [HASH_W-1:0] req_hash,
  input  logic [HASH_W-1:0] ref_hash,
  output logic              auth_request,
  output logic [HASH_W-1:0] input_hash,
  output logic [HASH_W-1:0] password_hash,
  input  logic              auth_result,
  output logic              rsp_valid,
  output logic              rsp_pass,
  input  logic              rsp_ready,
  output logic              locked,
  output logic [FAIL_W-1:0] fail_count
);

  localparam int TIMER_MAX = (COMPARE_CYCLES > LOCKOUT_CYCLES) ? COMPARE_CYCLES : LOCKOUT_CYCLES;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

  localparam logic [TIMER_W-1:0] WINDOW_LOAD = TIMER_W'(COMPARE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LOAD   = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [FAIL_W-1:0]  FAIL_MAX    = FAIL_W'(MAX_FAILS);

  auth_state_e        state, next_state;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_dec;
  logic [TIMER_W-1:0] timer_count;
  logic               timer_zero;

  logic               sample_result;
  logic               rsp_accept;
  logic               lock_done;
  logic               rsp_pass_q;
  logic [FAIL_W-1:0]  fail_inc;

  auth_cycle_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (timer_value),
    .dec        (timer_dec),
    .count      (timer_count),
    .zero       (timer_zero)
  );

  // Saturating increment of the failure streak.
  assign fail_inc = (fail_count == FAIL_MAX) ? fail_count : fail_count + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    next_state    = state;
    timer_load    = 1'b0;
    timer_value   = '0;
    timer_dec     = 1'b0;
    sample_result = 1'b0;
    rsp_accept    = 1'b0;
    lock_done     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) next_state = ISSUE;
      end
      ISSUE: begin
        timer_load  = 1'b1;
        timer_value = WINDOW_LOAD;
        next_state  = WAIT;
      end
      WAIT: begin
        // The verdict is looked at on the zero cycle only; earlier values may
        // be left over from a previous compare.
        if (timer_zero) begin
          sample_result = 1'b1;
          next_state    = RESPOND;
        end else begin
          timer_dec = 1'b1;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          rsp_accept = 1'b1;
          if (!rsp_pass_q && (fail_inc == FAIL_MAX)) begin
            timer_load  = 1'b1;
            timer_value = LOCK_LOAD;
            next_state  = LOCKOUT;
          end else begin
            next_state = IDLE;
          end
        end
      end
      LOCKOUT: begin
        if (timer_zero) begin
          lock_done  = 1'b1;
          next_state = IDLE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: the hash latches are ordinary flops and are cleared by reset so an
  // aborted credential never lingers on the responder interface.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      input_hash    <= '0;
      password_hash <= '0;
      rsp_pass_q    <= 1'b0;
      fail_count    <= '0;
    end else begin
      if (req_valid && req_ready) begin
        input_hash    <= req_hash;
        password_hash <= ref_hash;
      end
      if (sample_result) rsp_pass_q <= auth_result;
      if (rsp_accept) begin
        input_hash    <= '0;
        password_hash <= '0;
        rsp_pass_q    <= 1'b0;
        fail_count    <= rsp_pass_q ? '0 : fail_inc;
      end
      if (lock_done) fail_count <= '0;
    end
  end

  // Moore outputs. req_ready is also held low while reset is asserted so the
  // host sees every output at 0 during reset.
  assign req_ready    = reset_n && (state == IDLE);
  assign auth_request = (state == ISSUE);
  assign rsp_valid    = (state == RESPOND);
  assign rsp_pass     = (state == RESPOND) && rsp_pass_q;
  assign locked       = (state == LOCKOUT);

endmodule : auth_request_initiator

// File: tb/tb_auth_request_initiator.sv
module tb_auth_request_initiator;

  localparam int HASH_W = 32;
  localparam logic [31:0] H0 = 32'hA5A5_0F0F;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic [HASH_W-1:0] req_hash;
  logic [HASH_W-1:0] ref_hash;
  logic              auth_request;
  logic [HASH_W-1:0] input_hash;
  logic [HASH_W-1:0] password_hash;
  logic              auth_result;
  logic              rsp_valid;
  logic              rsp_pass;
  logic              rsp_ready;
  logic              locked;
  logic [1:0]        fail_count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  auth_request_initiator #(
    .HASH_W         (HASH_W),
    .COMPARE_CYCLES (24),
    .MAX_FAILS      (3),
    .LOCKOUT_CYCLES (256),
    .FAIL_W         (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_hash      (req_hash),
    .ref_hash      (ref_hash),
    .auth_request  (auth_request),
    .input_hash    (input_hash),
    .password_hash (password_hash),
    .auth_result   (auth_result),
    .rsp_valid     (rsp_valid),
    .rsp_pass      (rsp_pass),
    .rsp_ready     (rsp_ready),
    .locked        (locked),
    .fail_count    (fail_count)
  );

  // Compare responder model: decision time grows with the first mismatching
  // bit position; the previous verdict stays on auth_result until then.
  function automatic int first_diff(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 32; i++) if (a[i] != b[i]) return i;
    return 32;
  endfunction

  logic resp_pending;
  int   resp_cnt;
  logic resp_verdict;

  always @(posedge clk) begin
    if (!reset_n) begin
      resp_pending <= 1'b0;
      resp_cnt     <= 0;
      resp_verdict <= 1'b0;
      auth_result  <= 1'b0;
    end else if (auth_request) begin
      resp_pending <= 1'b1;
      resp_cnt     <= 2 + ((first_diff(input_hash, password_hash) > 16) ? 16
                                : first_diff(input_hash, password_hash));
      resp_verdict <= (input_hash == password_hash);
    end else if (resp_pending) begin
      if (resp_cnt == 0) begin
        auth_result  <= resp_verdict;
        resp_pending <= 1'b0;
      end else begin
        resp_cnt <= resp_cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives a credential at a negedge with the DUT in IDLE and follows it to
  // the first RESPOND cycle. Ends at a negedge with rsp_valid expected high.
  task automatic run_request(input string tag, input logic [31:0] rq,
                             input logic [31:0] rf, input logic exp_pass);
    int cyc;
    int pulses;
    int bad;
    req_valid = 1'b1;
    req_hash  = rq;
    ref_hash  = rf;
    chk({tag, "_ready"}, req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_hash  = $urandom;
    ref_hash  = $urandom;
    chk({tag, "_pulse"}, auth_request, 1);
    chk({tag, "_in_hash"}, input_hash, rq);
    chk({tag, "_pw_hash"}, password_hash, rf);
    cyc    = 1;
    pulses = 0;
    bad    = 0;
    while (!rsp_valid && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (auth_request) pulses++;
      if (req_ready || (!rsp_valid && rsp_pass)) bad++;
    end
    chk({tag, "_latency"}, cyc, 26);
    chk({tag, "_repulse"}, pulses, 0);
    chk({tag, "_window_outs"}, bad, 0);
    chk({tag, "_pass"}, rsp_pass, exp_pass);
    chk({tag, "_hold_hash"}, {input_hash, password_hash}, {rq, rf});
  endtask

  // Accepts the pending response; optionally presents a new credential in the
  // same cycle, which must not be taken until IDLE.
  task automatic accept(input string tag, input logic [1:0] exp_fc,
                        input logic exp_locked, input logic with_next);
    rsp_ready = 1'b1;
    if (with_next) begin
      req_valid = 1'b1;
      req_hash  = H0;
      ref_hash  = H0 ^ 32'h0000_4000;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_acc_valid"}, {rsp_valid, rsp_pass, auth_request}, 3'b000);
    chk({tag, "_acc_fc"}, fail_count, exp_fc);
    chk({tag, "_acc_locked"}, locked, exp_locked);
    chk({tag, "_acc_ready"}, req_ready, !exp_locked);
    chk({tag, "_acc_hash"}, {input_hash, password_hash}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    logic [63:0] hold_hash;

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_hash  = '0;
    ref_hash  = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {req_ready, auth_request, rsp_valid, rsp_pass, locked, fail_count}, 7'd0);
    chk("reset_hash", {input_hash, password_hash}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", req_ready, 1);

    // 1: matching hashes
    run_request("c1", H0, H0, 1'b1);
    chk("c1_fc", fail_count, 0);
    accept("c1", 2'd0, 1'b0, 1'b0);

    // 2: mismatch at bit 0, then at bit 14
    run_request("c2a", H0 ^ 32'h1, H0, 1'b0);
    accept("c2a", 2'd1, 1'b0, 1'b0);
    run_request("c2b", H0 ^ 32'h4000, H0, 1'b0);
    accept("c2b", 2'd2, 1'b0, 1'b0);

    // 3: pass then back-to-back fail; new credential offered during accept
    run_request("c3a", H0, H0, 1'b1);
    accept("c3a", 2'd0, 1'b0, 1'b1);
    run_request("c3b", H0, H0 ^ 32'h0000_4000, 1'b0);
    accept("c3b", 2'd1, 1'b0, 1'b0);

    // 5: response held 10 cycles while host keeps offering credentials
    run_request("c5", 32'h1234_5678, 32'h1234_5679, 1'b0);
    hold_hash = {input_hash, password_hash};
    req_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_pass || req_ready || auth_request ||
          ({input_hash, password_hash} !== {32'h1234_5678, 32'h1234_5679})) bad++;
    end
    req_valid = 1'b0;
    chk("c5_hold_stable", bad, 0);
    chk("c5_hold_hash", hold_hash, {32'h1234_5678, 32'h1234_5679});
    accept("c5", 2'd2, 1'b0, 1'b0);

    // 4: third consecutive fail enters lockout
    run_request("c4", 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    accept("c4", 2'd3, 1'b1, 1'b0);
    req_valid = 1'b1;
    req_hash  = H0;
    ref_hash  = H0;
    n   = 0;
    bad = 0;
    while (locked && n < 400) begin
      n++;
      if (req_ready || auth_request || fail_count != 2'd3) bad++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("c4_lock_len", n, 256);
    chk("c4_lock_outs", bad, 0);
    chk("c4_unlock", {locked, fail_count, req_ready}, 4'b0001);

    // 6: reset during WAIT aborts silently
    req_valid = 1'b1;
    req_hash  = H0;
    ref_hash  = H0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("c6_reset_outs", {req_ready, auth_request, rsp_valid, rsp_pass, locked, fail_count}, 7'd0);
    chk("c6_reset_hash", {input_hash, password_hash}, 64'd0);
    reset_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid || auth_request || !req_ready) bad++;
    end
    chk("c6_silent", bad, 0);
    run_request("c6", H0, H0, 1'b1);
    accept("c6", 2'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_auth_request_initiator
